// File: rtl/sd_cmd_engine.sv
// SD-card SPI-mode command sequencer: frames a 6-byte command, polls for R1, optionally
// waits for the start token and streams one data block out on a valid/ready byte port.
module sd_cmd_engine #(
  parameter int unsigned RESP_POLLS  = 8,
  parameter int unsigned TOKEN_POLLS = 1024,
  parameter logic [7:0]  DATA_TOKEN  = 8'hFE,
  parameter int unsigned BLOCK_LEN   = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic        cmd_has_data,
  output logic        cmd_busy,
  output logic        cmd_done,
  output logic [7:0]  cmd_resp,
  output logic [1:0]  cmd_err,
  output logic [7:0]  data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        spi_req,
  output logic        spi_tx_en,
  output logic [7:0]  spi_data_tx,
  input  logic        spi_busy,
  input  logic [7:0]  spi_data_rx
);

  localparam int unsigned MaxLim =
      (TOKEN_POLLS > BLOCK_LEN) ?
      ((TOKEN_POLLS > RESP_POLLS) ? TOKEN_POLLS : RESP_POLLS) :
      ((BLOCK_LEN > RESP_POLLS) ? BLOCK_LEN : RESP_POLLS);
  localparam int unsigned CW = (MaxLim < 8) ? 3 : $clog2(MaxLim + 1);

  localparam logic [CW-1:0] RespLast  = CW'(RESP_POLLS - 1);
  localparam logic [CW-1:0] TokenLast = CW'(TOKEN_POLLS - 1);
  localparam logic [CW-1:0] BlockLast = CW'(BLOCK_LEN - 1);
  localparam logic [CW-1:0] FrameLast = CW'(5);
  localparam logic [CW-1:0] CrcLast   = CW'(1);
  localparam logic [CW-1:0] CntOne    = CW'(1);

  typedef enum logic [2:0] {
    StIdle, StSend, StPollResp, StWaitToken, StRead, StCrc, StDone
  } state_t;

  // Every non-idle state moves bytes through the same issue / wait-high / wait-low handshake.
  typedef enum logic [1:0] {PhIssue, PhWaitHi, PhWaitLo} phase_t;

  state_t        state_q;
  phase_t        phase_q;
  logic [CW-1:0] cnt_q;
  logic [5:0]    idx_q;
  logic [31:0]   arg_q;
  logic [6:0]    crc_q;
  logic          has_data_q;
  logic [7:0]    frame_byte;

  always_comb begin
    frame_byte = 8'hFF;
    case (cnt_q[2:0])
      3'd0:    frame_byte = {2'b01, idx_q};
      3'd1:    frame_byte = arg_q[31:24];
      3'd2:    frame_byte = arg_q[23:16];
      3'd3:    frame_byte = arg_q[15:8];
      3'd4:    frame_byte = arg_q[7:0];
      3'd5:    frame_byte = {crc_q, 1'b1};
      default: frame_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_q     <= PhIssue;
      cnt_q       <= '0;
      idx_q       <= '0;
      arg_q       <= '0;
      crc_q       <= '0;
      has_data_q  <= 1'b0;
      cmd_busy    <= 1'b0;
      cmd_done    <= 1'b0;
      cmd_resp    <= '0;
      cmd_err     <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      spi_req     <= 1'b0;
      spi_tx_en   <= 1'b0;
      spi_data_tx <= '0;
    end else begin
      cmd_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_start) begin
            idx_q      <= cmd_index;
            arg_q      <= cmd_arg;
            crc_q      <= cmd_crc;
            has_data_q <= cmd_has_data;
            cmd_busy   <= 1'b1;
            cmd_resp   <= '0;
            cmd_err    <= '0;
            cnt_q      <= '0;
            phase_q    <= PhIssue;
            state_q    <= StSend;
          end
        end
        StDone: state_q <= StIdle;
        default: begin
          unique case (phase_q)
            PhIssue: begin
              if (state_q == StRead && data_valid) begin
                // No skid buffer: the next byte is only fetched once this one is taken.
                if (data_ready) begin
                  data_valid <= 1'b0;
                  if (cnt_q == BlockLast) begin
                    cnt_q   <= '0;
                    state_q <= StCrc;
                  end else begin
                    cnt_q <= cnt_q + CntOne;
                  end
                end
              end else if (!spi_busy) begin
                spi_req <= 1'b1;
                phase_q <= PhWaitHi;
                if (state_q == StSend) begin
                  spi_tx_en   <= 1'b1;
                  spi_data_tx <= frame_byte;
                end else begin
                  spi_tx_en   <= 1'b0;
                  spi_data_tx <= 8'hFF;
                end
              end
            end
            PhWaitHi: begin
              spi_req <= 1'b0;
              if (spi_busy) phase_q <= PhWaitLo;
            end
            PhWaitLo: begin
              if (!spi_busy) begin
                phase_q <= PhIssue;
                case (state_q)
                  StSend: begin
                    if (cnt_q == FrameLast) begin
                      cnt_q   <= '0;
                      state_q <= StPollResp;
                    end else begin
                      cnt_q <= cnt_q + CntOne;
                    end
                  end
                  StPollResp: begin
                    if (!spi_data_rx[7]) begin
                      cmd_resp <= spi_data_rx;
                      cnt_q    <= '0;
                      if (!has_data_q) begin
                        state_q  <= StDone;
                        cmd_done <= 1'b1;
                        cmd_busy <= 1'b0;
                      end else if (spi_data_rx != 8'h00) begin
                        cmd_err  <= 2'b11;
                        state_q  <= StDone;
                        cmd_done <= 1'b1;
                        cmd_busy <= 1'b0;
                      end else begin
                        state_q <= StWaitToken;
                      end
                    end else if (cnt_q == RespLast) begin
                      cmd_err  <= 2'b01;
                      state_q  <= StDone;
                      cmd_done <= 1'b1;
                      cmd_busy <= 1'b0;
                    end else begin
                      cnt_q <= cnt_q + CntOne;
                    end
                  end
                  StWaitToken: begin
                    if (spi_data_rx == DATA_TOKEN) begin
                      cnt_q   <= '0;
                      state_q <= StRead;
                    end else if (cnt_q == TokenLast) begin
                      cmd_err  <= 2'b10;
                      state_q  <= StDone;
                      cmd_done <= 1'b1;
                      cmd_busy <= 1'b0;
                    end else begin
                      cnt_q <= cnt_q + CntOne;
                    end
                  end
                  StRead: begin
                    data_out   <= spi_data_rx;
                    data_valid <= 1'b1;
                  end
                  StCrc: begin
                    if (cnt_q == CrcLast) begin
                      cnt_q    <= '0;
                      state_q  <= StDone;
                      cmd_done <= 1'b1;
                      cmd_busy <= 1'b0;
                    end else begin
                      cnt_q <= cnt_q + CntOne;
                    end
                  end
                  default: state_q <= StIdle;
                endcase
              end
            end
            default: phase_q <= PhIssue;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Table-driven bench for sd_cmd_engine with a behavioural SPI master and a byte scoreboard.
module tb_sd_cmd_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic [6:0]  cmd_crc = '0;
  logic        cmd_has_data = 1'b0;
  logic        cmd_busy, cmd_done, data_valid, spi_req, spi_tx_en;
  logic [7:0]  cmd_resp, data_out, spi_data_tx;
  logic [1:0]  cmd_err;
  logic        data_ready = 1'b0;
  logic        spi_busy;
  logic [7:0]  spi_data_rx;

  always #5 clk = ~clk;

  sd_cmd_engine dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_start    (cmd_start),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .cmd_crc      (cmd_crc),
    .cmd_has_data (cmd_has_data),
    .cmd_busy     (cmd_busy),
    .cmd_done     (cmd_done),
    .cmd_resp     (cmd_resp),
    .cmd_err      (cmd_err),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .spi_req      (spi_req),
    .spi_tx_en    (spi_tx_en),
    .spi_data_tx  (spi_data_tx),
    .spi_busy     (spi_busy),
    .spi_data_rx  (spi_data_rx)
  );

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic        has_data;
    int          nff;
    logic        resp_present;
    logic [7:0]  resp;
    int          ntok;
    logic        tok_present;
    int          ready_mode;
    logic [7:0]  seed;
    logic [1:0]  exp_err;
    logic [7:0]  exp_resp;
    int          exp_polls;
  } vec_t;

  localparam int NVec = 8;
  localparam int Budget = 20000;
  vec_t vecs [NVec];

  int errors = 0;
  int checks = 0;
  logic [7:0] miso_q[$];
  logic [7:0] exp_mosi[$];
  logic [7:0] exp_data[$];
  int nontx_cnt, mosi_cnt, data_cnt, exp_data_cnt;
  int ready_mode = 0;
  int cyc = 0;
  int bcnt;
  logic [7:0] pend;
  logic hold_valid = 1'b0;
  logic [7:0] hold_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SPI master model: busy for 3 cycles per byte, MISO bytes from miso_q (0xFF when empty).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_busy    <= 1'b0;
      spi_data_rx <= 8'h00;
      bcnt        <= 0;
      pend        <= 8'hFF;
    end else if (spi_req) begin
      if (spi_busy) begin
        errors++;
        $display("FAIL req_while_busy: spi_req=1 with spi_busy=1");
      end
      if (data_valid && !data_ready) begin
        errors++;
        $display("FAIL req_during_backpressure: spi_req=1 with data pending");
      end
      if (spi_tx_en) begin
        mosi_cnt++;
        if (exp_mosi.size() == 0) begin
          check("extra_frame_byte", {24'h0, spi_data_tx}, 32'hFFFF_FFFF);
        end else begin
          check("mosi_byte", {24'h0, spi_data_tx}, {24'h0, exp_mosi.pop_front()});
        end
        pend <= 8'hFF;
      end else begin
        nontx_cnt++;
        pend <= (miso_q.size() != 0) ? miso_q.pop_front() : 8'hFF;
      end
      spi_busy <= 1'b1;
      bcnt     <= 3;
    end else if (spi_busy) begin
      if (bcnt == 1) begin
        spi_busy    <= 1'b0;
        spi_data_rx <= pend;
      end
      bcnt <= bcnt - 1;
    end
  end

  // Downstream consumer: drives data_ready and checks accepted bytes against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      data_ready = 1'b0;
      hold_valid = 1'b0;
    end else begin
      data_ready = (ready_mode == 0) || (cyc % 3 == 0);
      cyc++;
      if (data_valid && hold_valid && data_out !== hold_out) begin
        errors++;
        $display("FAIL data_stable: data_out changed %0h -> %0h while held", hold_out, data_out);
      end
      if (data_valid && data_ready) begin
        data_cnt++;
        if (exp_data.size() == 0) check("extra_data_byte", {24'h0, data_out}, 32'hFFFF_FFFF);
        else check("data_byte", {24'h0, data_out}, {24'h0, exp_data.pop_front()});
        hold_valid = 1'b0;
      end else begin
        hold_valid = data_valid;
        hold_out   = data_out;
      end
    end
  end

  task automatic setup(input int t);
    vec_t v;
    logic [7:0] b;
    v = vecs[t];
    miso_q.delete();
    exp_mosi.delete();
    exp_data.delete();
    nontx_cnt = 0;
    mosi_cnt = 0;
    data_cnt = 0;
    exp_data_cnt = 0;
    ready_mode = v.ready_mode;
    exp_mosi.push_back({2'b01, v.idx});
    exp_mosi.push_back(v.arg[31:24]);
    exp_mosi.push_back(v.arg[23:16]);
    exp_mosi.push_back(v.arg[15:8]);
    exp_mosi.push_back(v.arg[7:0]);
    exp_mosi.push_back({v.crc, 1'b1});
    for (int i = 0; i < v.nff; i++) miso_q.push_back(8'hFF);
    if (v.resp_present) miso_q.push_back(v.resp);
    if (v.has_data && v.resp_present && v.resp == 8'h00) begin
      for (int i = 0; i < v.ntok; i++) miso_q.push_back(8'hFF);
      if (v.tok_present) begin
        miso_q.push_back(8'hFE);
        for (int i = 0; i < 512; i++) begin
          b = i[7:0] + v.seed;
          miso_q.push_back(b);
          exp_data.push_back(b);
        end
        exp_data_cnt = 512;
        miso_q.push_back(8'hAB);
        miso_q.push_back(8'hCD);
      end
    end
  endtask

  task automatic start(input int t);
    @(negedge clk);
    cmd_index    = vecs[t].idx;
    cmd_arg      = vecs[t].arg;
    cmd_crc      = vecs[t].crc;
    cmd_has_data = vecs[t].has_data;
    cmd_start    = 1'b1;
    @(negedge clk);
    cmd_start    = 1'b0;
    // Scramble the fields: the engine must use the values latched at acceptance.
    cmd_index    = ~vecs[t].idx;
    cmd_arg      = ~vecs[t].arg;
    cmd_crc      = ~vecs[t].crc;
    cmd_has_data = ~vecs[t].has_data;
    check($sformatf("t%0d busy_after_start", t), {31'h0, cmd_busy}, 32'h1);
  endtask

  task automatic finish_cmd(input int t);
    int c;
    c = 0;
    while (c < Budget && !cmd_done) begin
      @(negedge clk);
      c++;
    end
    check($sformatf("t%0d done_seen", t), {31'h0, cmd_done}, 32'h1);
    if (cmd_done) begin
      check($sformatf("t%0d busy_at_done", t), {31'h0, cmd_busy}, 32'h0);
      check($sformatf("t%0d resp", t), {24'h0, cmd_resp}, {24'h0, vecs[t].exp_resp});
      check($sformatf("t%0d err", t), {30'h0, cmd_err}, {30'h0, vecs[t].exp_err});
      check($sformatf("t%0d poll_transfers", t), nontx_cnt, vecs[t].exp_polls);
      check($sformatf("t%0d frame_bytes", t), mosi_cnt, 6);
      check($sformatf("t%0d data_bytes", t), data_cnt, exp_data_cnt);
    end
  endtask

  task automatic run(input int t);
    setup(t);
    start(t);
    finish_cmd(t);
  endtask

  initial begin
    //          idx     arg            crc    hd    nff rp    resp   ntok tp  rm sd     err    resp   polls
    vecs[0] = '{6'd0,  32'h0000_0000, 7'h4A, 1'b0, 2, 1'b1, 8'h01, 0,    1'b0, 0, 8'h00, 2'b00, 8'h01, 3};
    vecs[1] = '{6'd8,  32'h0000_01AA, 7'h43, 1'b0, 0, 1'b0, 8'h00, 0,    1'b0, 0, 8'h00, 2'b01, 8'h00, 8};
    vecs[2] = '{6'd17, 32'h0000_1200, 7'h2A, 1'b1, 0, 1'b1, 8'h00, 3,    1'b1, 0, 8'h00, 2'b00, 8'h00, 519};
    vecs[3] = '{6'd17, 32'h0012_3400, 7'h11, 1'b1, 1, 1'b1, 8'h00, 0,    1'b1, 1, 8'h80, 2'b00, 8'h00, 517};
    vecs[4] = '{6'd17, 32'hFFFF_0000, 7'h05, 1'b1, 1, 1'b1, 8'h04, 0,    1'b0, 0, 8'h00, 2'b11, 8'h04, 2};
    vecs[5] = '{6'd17, 32'h0000_0200, 7'h7F, 1'b1, 0, 1'b1, 8'h00, 0,    1'b0, 0, 8'h00, 2'b10, 8'h00, 1025};
    vecs[6] = '{6'd55, 32'hDEAD_BEEF, 7'h33, 1'b0, 7, 1'b1, 8'h05, 0,    1'b0, 0, 8'h00, 2'b00, 8'h05, 8};
    vecs[7] = '{6'd17, 32'h0000_0400, 7'h1C, 1'b1, 0, 1'b1, 8'h00, 1023, 1'b1, 0, 8'h3C, 2'b00, 8'h00, 1539};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {cmd_busy, cmd_done, cmd_resp, cmd_err, data_out, data_valid,
                            spi_req, spi_tx_en, spi_data_tx}, 32'h0);
    rst = 1'b0;

    for (int t = 0; t < NVec - 1; t++) run(t);

    // cmd_start during the DONE cycle must be ignored.
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (4) @(negedge clk);
    check("start_in_done_busy", {31'h0, cmd_busy}, 32'h0);
    check("start_in_done_no_frame", mosi_cnt, 6);

    run(NVec - 1);

    // Reset in the middle of a block read, then a fresh command.
    setup(2);
    start(2);
    for (int c = 0; c < Budget && data_cnt < 100; c++) @(negedge clk);
    check("mid_read_reached", {31'h0, data_cnt >= 100}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("mid_read_reset_outputs", {cmd_busy, cmd_done, cmd_resp, cmd_err, data_out,
                                     data_valid, spi_req, spi_tx_en, spi_data_tx}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
